// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared types for the five-stage MIPS core: register and
//                opcode encodings, PC source selects and the pipeline
//                controller state type, plus the MEM-stage redirect decode.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    localparam int REG_W = 5;
    localparam int OP_W  = 6;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [OP_W-1:0] {
        RTYPE  = 6'h00,
        J      = 6'h02,
        JAL    = 6'h03,
        BEQ    = 6'h04,
        BNE    = 6'h05,
        ADDI   = 6'h08,
        LW     = 6'h23,
        SW     = 6'h2B,
        HALTOP = 6'h3F
    } opcode_t;

    // PC source selects as latched in EX/MEM
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_JR     = 2'b11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } pipe_state_t;

    // Jumps always redirect; branches only when the zero flag agrees with the
    // branch sense.
    function automatic logic redirect_taken(input logic [1:0] pc_src,
                                            input opcode_t    opcode,
                                            input logic       zero);
        logic t;
        t = 1'b0;
        if (pc_src == PCSRC_JUMP || pc_src == PCSRC_JR) begin
            t = 1'b1;
        end else if (pc_src == PCSRC_BRANCH) begin
            t = (opcode == BEQ &&  zero) ||
                (opcode == BNE && !zero);
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Load-use comparator. Flags when the load in EX writes a
//                register that the instruction in ID reads.
//  Revision    : 1.0  initial release
//  Ports       : memtoreg_ex_i  EX instruction is a load
//                regwr_ex_i     EX instruction writes a register
//                wsel_ex_i      EX destination register
//                rs_id_i/rt_id_i ID source registers
//                luse_o         load-use hazard present
// ============================================================================
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     memtoreg_ex_i,
    input  logic     regwr_ex_i,
    input  regbits_t wsel_ex_i,
    input  regbits_t rs_id_i,
    input  regbits_t rt_id_i,
    output logic     luse_o
);

    // $zero is never a real dependency
    assign luse_o = memtoreg_ex_i && regwr_ex_i && (wsel_ex_i != '0) &&
                    ((wsel_ex_i == rs_id_i) || (wsel_ex_i == rt_id_i));

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Pipeline sequencing controller. Drives latch enables/flushes
//                and the PC write enable from I/D-memory status, load-use
//                hazards, MEM-stage redirects and halt. Keeps saturating
//                stall and redirect counters.
//  Revision    : 1.0  initial release
//  Ports       : CLK, RST (sync, active high)
//                ihit, dhit                      memory status
//                memtoReg_EX, RegWr_EX, wsel_EX  EX-stage load info
//                rs_ID, rt_ID                    ID-stage sources
//                memtoReg_MEM, memWr_MEM         MEM-stage data request
//                PC_Src_MEM, opcode_MEM, zero_MEM redirect decode
//                halt_WB                         HALT reached WB
//                pc_en, redirect, *_en, *_flush  combinational controls
//                halted, stall_cnt, redirect_cnt registered status
// ============================================================================
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             memtoReg_EX,
    input  logic             RegWr_EX,
    input  regbits_t         wsel_EX,
    input  regbits_t         rs_ID,
    input  regbits_t         rt_ID,
    input  logic             memtoReg_MEM,
    input  logic             memWr_MEM,
    input  logic [1:0]       PC_Src_MEM,
    input  opcode_t          opcode_MEM,
    input  logic             zero_MEM,
    input  logic             halt_WB,
    output logic             pc_en,
    output logic             redirect,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    pipe_state_t      state_q;
    logic             ihit_seen_q;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] redirect_cnt_q;

    logic w_luse;
    logic w_taken;
    logic w_dreq;
    logic w_dblock;
    logic w_ihit_eff;

    hazard_detect u_hazard_detect (
        .memtoreg_ex_i (memtoReg_EX),
        .regwr_ex_i    (RegWr_EX),
        .wsel_ex_i     (wsel_EX),
        .rs_id_i       (rs_ID),
        .rt_id_i       (rt_ID),
        .luse_o        (w_luse)
    );

    assign w_taken = redirect_taken(PC_Src_MEM, opcode_MEM, zero_MEM);
    assign w_dreq  = memtoReg_MEM | memWr_MEM;

    // In DWAIT the request is already known outstanding, so only dhit matters.
    // A fetch that completed while frozen is remembered in ihit_seen_q.
    assign w_dblock   = (state_q == DWAIT) ? !dhit : (w_dreq && !dhit);
    assign w_ihit_eff = (state_q == DWAIT) ? (ihit | ihit_seen_q) : ihit;

    always_comb begin
        pc_en       = 1'b0;
        redirect    = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (RST) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (halt_WB || state_q == HALT) begin
            // frozen: everything stays deasserted
        end else if (w_dblock) begin
            // freeze the whole pipe, bubble into WB so nothing retires twice
            memwb_flush = 1'b1;
        end else if (w_taken) begin
            // redirect outranks load-use: the dependent ID instruction is
            // squashed anyway
            pc_en       = 1'b1;
            redirect    = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_luse) begin
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            idex_flush  = 1'b1;
        end else if (!w_ihit_eff) begin
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
        end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= RUN;
            ihit_seen_q    <= 1'b0;
            halted_q       <= 1'b0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (state_q != HALT && !pc_en && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (redirect && redirect_cnt_q != '1) begin
                redirect_cnt_q <= redirect_cnt_q + 1'b1;
            end

            if (halt_WB) begin
                state_q     <= HALT;
                halted_q    <= 1'b1;
                ihit_seen_q <= 1'b0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (w_dreq && !dhit) begin
                            state_q     <= DWAIT;
                            ihit_seen_q <= ihit;
                        end
                    end
                    DWAIT: begin
                        if (!dhit) begin
                            ihit_seen_q <= ihit_seen_q | ihit;
                        end else begin
                            state_q     <= RUN;
                            ihit_seen_q <= 1'b0;
                        end
                    end
                    HALT: begin
                        state_q <= HALT;
                    end
                    default: begin
                        state_q <= RUN;
                    end
                endcase
            end
        end
    end

    assign halted       = halted_q;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It generates the enable and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline latches and the PC write enable. It handles instruction-memory misses, data-memory waits, load-use hazards, branch/jump redirects resolved in MEM, and halt. It also keeps saturating stall and redirect counters for performance debug.

## Interface
- Parameters:
  - `CNT_W`, default 16: width of the performance counters.
- Ports:
  - `CLK`  in  1  core clock; all state updates on the rising edge.
  - `RST`  in  1  synchronous, active-high reset.
  - `ihit`  in  1  instruction memory returned `instr` this cycle.
  - `dhit`  in  1  data memory completed the MEM-stage access this cycle.
  - `memtoReg_EX`, `RegWr_EX`  in  1 each  EX-stage instruction is a load / writes a register.
  - `wsel_EX`  in  5 (`regbits_t`)  EX-stage destination register.
  - `rs_ID`, `rt_ID`  in  5 each  ID-stage source registers.
  - `memtoReg_MEM`, `memWr_MEM`  in  1 each  MEM-stage read / write request.
  - `PC_Src_MEM`  in  2  00 = PC+4, 01 = branch, 10 = jump, 11 = JR.
  - `opcode_MEM`  in  `opcode_t`  MEM-stage opcode.
  - `zero_MEM`  in  1  ALU zero flag latched in EX/MEM.
  - `halt_WB`  in  1  HALT instruction is in MEM/WB.
  - `pc_en`  out  1  PC register write enable.
  - `redirect`  out  1  PC takes the MEM-stage target (branch, jump or JR).
  - `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  latch enables.
  - `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  load a bubble; flush wins over enable.
  - `halted`  out  1  sticky halt status.
  - `stall_cnt`, `redirect_cnt`  out  `CNT_W` each  saturating counters.

## Operation
- FSM (`pipe_state_t`) has three states: RUN, DWAIT, HALT.
- `dreq = memtoReg_MEM | memWr_MEM`.
- `taken` is true when any of the following holds:
  - `PC_Src_MEM` is 10 or 11;
  - `PC_Src_MEM` = 01 and opcode is BEQ and `zero_MEM`;
  - `PC_Src_MEM` = 01 and opcode is BNE and not `zero_MEM`.
- `luse = memtoReg_EX & RegWr_EX & wsel_EX != 0 & (wsel_EX == rs_ID | wsel_EX == rt_ID)`.
- Behaviour in RUN, in priority order:
  1. `dreq & !dhit`: all enables 0, `pc_en` 0, `memwb_flush` 1. Next state DWAIT; `ihit_seen <= ihit`.
  2. `taken`: all enables 1, `pc_en` 1, `redirect` 1, `ifid_flush`/`idex_flush`/`exmem_flush` 1. This holds regardless of `ihit`.
  3. `luse`: `pc_en` 0, `ifid_en` 0, `idex_flush` 1; EX/MEM and MEM/WB advance.
  4. `!ihit`: `pc_en` 0, `ifid_flush` 1; the other latches advance.
  5. Otherwise: all enables 1, all flushes 0, `pc_en` 1.
- Behaviour in DWAIT:
  - While `!dhit`: outputs as in RUN case 1; `ihit_seen <= ihit_seen | ihit`.
  - On `dhit`: return to RUN and re-evaluate `taken`/`luse` as in RUN with `dreq` treated as satisfied. The `!ihit` case uses `ihit | ihit_seen`. Clear `ihit_seen`.
- HALT: entered from any state when `halt_WB` = 1 (highest priority).
  - All enables 0, `pc_en` 0, flushes 0, `halted` 1.
  - Exits only on `RST`.
- `stall_cnt` increments on every non-HALT cycle with `pc_en` = 0.
- `redirect_cnt` increments on every cycle with `redirect` = 1.
- Both counters saturate at all-ones; they never wrap.

## Timing
- Control outputs are combinational from the current state and inputs, valid in the same cycle.
- `halted`, the state, `ihit_seen` and both counters are registered and update on the next edge.
- Reset values:
  - State RUN, `halted` 0, `ihit_seen` 0, counters 0.
  - While `RST` = 1: all enables 0, all flushes 1, `pc_en` 0, `redirect` 0.
- `RST` asserted mid-DWAIT: the FSM returns to RUN on that edge and pending `ihit_seen` is discarded.
- Load-use costs exactly one stall cycle.
- A taken redirect costs three squashed instructions and no extra cycles.
- `dhit` in the same cycle as the request: no stall, and the FSM stays in RUN.
- `taken` and `luse` together: the redirect wins, because the squashed ID instruction makes the stall moot.

## Structure
- `cpu_types_pkg` gains the `pipe_state_t` enum (RUN, DWAIT, HALT) and reuses the existing `opcode_t`, `regbits_t`, BEQ and BNE definitions.
- One sub-module, `hazard_detect`: a combinational load-use comparator producing `luse`, instantiated once.

## Test plan
- Reset, then `ihit` = 1 with no hazards -> all enables 1, all flushes 0, `pc_en` 1; `stall_cnt` stays 0.
- `memtoReg_EX` = 1, `RegWr_EX` = 1, `wsel_EX` = 5, `rs_ID` = 5 -> one cycle of `pc_en` 0, `ifid_en` 0, `idex_flush` 1; `stall_cnt` = 1. Repeat with `wsel_EX` = 0 -> no stall.
- `memtoReg_MEM` = 1, `dhit` = 0 for 3 cycles with `ihit` pulsed in cycle 2, then `dhit` = 1:
  - cycles 1-3: DWAIT, all enables 0, `memwb_flush` 1;
  - cycle 4: all enables 1 and `ifid_flush` 0 (from `ihit_seen`);
  - `stall_cnt` = 3.
- BEQ in MEM with `zero_MEM` = 1 -> `redirect` 1, IF/ID, ID/EX and EX/MEM flushes 1, `pc_en` 1, `redirect_cnt` = 1. BNE with `zero_MEM` = 1 -> no redirect.
- `halt_WB` = 1 -> `halted` 1 next cycle; outputs frozen despite `ihit`/`dhit` toggling. `RST` -> `halted` 0, state RUN.
- Taken jump plus `luse` in the same cycle -> `redirect` 1, `pc_en` 1. `RST` mid-DWAIT -> RUN next cycle; `stall_cnt` 0.
